sram_axi_bridge_mc: RTL and testbench
=====================================

// Module: sram_axi_bridge_mc
// PURPOSE
//  Multi-channel SRAM-like to AXI3 master bridge; successor to the fixed two-port (inst/data) bridge.
//  NUM_CH SRAM-like request ports share one AXI master.
//  Sits between the core-side SRAM arbiter and the AXI address-remap stage (MMU).
//  Fixed-priority grant, single transaction in flight, AXI ID = granted channel index.
//  Optional early write completion.
// PARAMETERS
//  NUM_CH      2   number of SRAM-like request channels (1..8); channel 0 has highest priority
//  WR_EARLY    0   1: ch_data_ok for a write pulses on the W handshake; 0: on the B handshake
//  ID_W        4   width of AXI ID fields; must satisfy 2**ID_W >= NUM_CH
// PORTS
//  clk          in   1            clock; all logic on rising edge
//  rst          in   1            synchronous reset, active-high
//  ch_req       in   NUM_CH       per-channel request
//  ch_wr        in   NUM_CH       1 = write, 0 = read
//  ch_size      in   2*NUM_CH     0 = byte, 1 = half, 2 = word; channel i at [2i+1:2i]
//  ch_addr      in   32*NUM_CH    byte address; channel i at [32i+31:32i]
//  ch_wdata     in   32*NUM_CH    write data, lane-aligned to addr[1:0]
//  ch_addr_ok   out  NUM_CH       request accepted (one-cycle, combinational)
//  ch_data_ok   out  NUM_CH       transaction complete (one-cycle, registered)
//  ch_rdata     out  32           read data, shared; valid only while ch_data_ok[i] is high for a read
//  bus_err      out  1            one-cycle pulse when rresp or bresp is nonzero
//  arid/araddr/arsize/arvalid  out  ID_W/32/3/1   AR channel; arready in 1
//  rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1   R channel; rready out 1
//  awid/awaddr/awsize/awvalid  out  ID_W/32/3/1   AW channel; awready in 1
//  wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1   W channel; wready in 1
//  bid/bresp/bvalid  in  ID_W/2/1   B channel; bready out 1
//  Tied constants: ar/awlen 0, ar/awburst 2'b01, ar/awlock 0, ar/awcache 0, ar/awprot 0
// BEHAVIOUR
//  Reset: all valids, readies, ch_addr_ok, ch_data_ok and bus_err are 0; ch_rdata is 0; FSM is IDLE.
//  FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B.
//  Grant: in IDLE, g = lowest index with ch_req[g]=1. ch_addr_ok[g]=1 in that same cycle, no other bit set.
//   On that cycle, latch id=g, wr, size, addr, wdata.
//   Transitions: IDLE -> RD_A if wr=0; IDLE -> WR_AW if wr=1.
//   ch_addr_ok is 0 in every state except IDLE.
//  RD_A: arvalid=1 with latched addr, arsize={1'b0,size}, arid=id. Stay until arready; then RD_D.
//  RD_D: rready=1. On rvalid (rid is ignored): register rdata into ch_rdata, pulse ch_data_ok[id] next cycle.
//   bus_err pulses next cycle if rresp!=0. Go to IDLE.
//  WR_AW: awvalid and wvalid both rise on entry; each drops independently after its own handshake.
//   Same-cycle handshakes are legal. Enter WR_B when both AW and W handshakes are done.
//   wlast=1 with wvalid. wid=awid=id.
//   wstrb: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
//  WR_B: bready=1. On bvalid, go to IDLE; bus_err pulses next cycle if bresp!=0.
//   WR_EARLY=0: ch_data_ok[id] pulses the cycle after the B handshake.
//   WR_EARLY=1: ch_data_ok[id] pulses the cycle after the W handshake and does NOT pulse again on B.
//   In both modes no new grant happens before the FSM returns to IDLE.
//  Latency, zero-wait slave: read addr_ok -> data_ok = 3 cycles; write (WR_EARLY=0) = 3 cycles.
//  Back-to-back: a grant is possible in the same cycle ch_data_ok pulses, because the FSM is already in IDLE.
//  Simultaneous requests: lower index wins. Losers hold ch_req and are served later.
//   No fairness guarantee: a continuously requesting channel 0 starves the others; accepted.
//  A requester's ch_req/addr/size/wdata may change after ch_addr_ok; the latched values are used.
//  size=3 is illegal: treated as word for strobes, arsize/awsize pass through unchanged.
//  Reset mid-operation: FSM returns to IDLE and valids drop, with no transaction completion.
//   The system resets the AXI slave in the same cycle.
// TESTING
//  1. NUM_CH=2, ch_req=2'b01 read 0x1FC0_0004, zero-wait slave returns 0xDEADBEEF
//     -> araddr=0x1FC00004, arid=0, arsize=2; ch_data_ok=2'b01 and ch_rdata=0xDEADBEEF 3 cycles after addr_ok.
//  2. ch_req=2'b11 same cycle, ch0 read, ch1 write -> ch_addr_ok=2'b01 first.
//     ch1 gets addr_ok in the ch0 data_ok cycle; awid=1.
//  3. Byte write, addr 0x...03, wdata 0xAB000000 -> wstrb=4'b1000.
//     Half write, addr 0x...02 -> wstrb=4'b1100.
//  4. awready held low 5 cycles while wready=1 -> wvalid drops after 1 cycle; awvalid holds.
//     WR_B is entered only after the AW handshake.
//  5. WR_EARLY=1, bvalid delayed 4 cycles -> ch_data_ok pulses after W; exactly one pulse total.
//     Next addr_ok only after B.
//  6. rresp=2'b10 on a read -> bus_err=1 for one cycle, aligned with ch_data_ok.
//     rst asserted in RD_D -> all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/sram_axi_bridge_mc_if.sv
// AXI3 master-side bundle for sram_axi_bridge_mc: AR/R/AW/W/B channels plus the
// tied-off burst/lock/cache/prot attributes the bridge always presents.
interface sram_axi_bridge_mc_if #(
   parameter int ID_W = 4
);
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [2:0]      arsize;
   logic [3:0]      arlen;
   logic [1:0]      arburst;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [2:0]      awsize;
   logic [3:0]      awlen;
   logic [1:0]      awburst;
   logic [1:0]      awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;

   logic [ID_W-1:0] wid;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awsize, awlen, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awsize, awlen, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/sram_axi_bridge_mc.sv
// NUM_CH SRAM-like request ports sharing one AXI3 master: fixed priority (channel 0 highest),
// one transaction in flight, AXI ID = granted channel, optional early write completion.
module sram_axi_bridge_mc #(
   parameter int NUM_CH   = 2,
   parameter int WR_EARLY = 0,
   parameter int ID_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     ch_req,
   input  logic [NUM_CH-1:0]     ch_wr,
   input  logic [2*NUM_CH-1:0]   ch_size,
   input  logic [32*NUM_CH-1:0]  ch_addr,
   input  logic [32*NUM_CH-1:0]  ch_wdata,
   output logic [NUM_CH-1:0]     ch_addr_ok,
   output logic [NUM_CH-1:0]     ch_data_ok,
   output logic [31:0]           ch_rdata,
   output logic                  bus_err,
   sram_axi_bridge_mc_if.master  axi
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

   state_t state, state_nxt;

   logic [ID_W-1:0]   id_q;
   logic [1:0]        size_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              aw_done;
   logic              w_done;

   logic              gnt_vld;
   logic [ID_W-1:0]   gnt_id;
   logic              gnt_wr;
   logic [1:0]        gnt_size;
   logic [31:0]       gnt_addr;
   logic [31:0]       gnt_wdata;
   logic [NUM_CH-1:0] gnt_onehot;
   logic [NUM_CH-1:0] id_onehot;
   logic              done_set;
   logic              err_set;
   logic              unused_ok;

   // Walk from the top so the lowest requesting index is the last (winning) assignment.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (no latch).
      gnt_vld    = 1'b0;
      gnt_id     = '0;
      gnt_wr     = 1'b0;
      gnt_size   = '0;
      gnt_addr   = '0;
      gnt_wdata  = '0;
      gnt_onehot = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_req[i]) begin
            gnt_vld       = 1'b1;
            gnt_id        = ID_W'(i);
            gnt_wr        = ch_wr[i];
            gnt_size      = ch_size[2*i +: 2];
            gnt_addr      = ch_addr[32*i +: 32];
            gnt_wdata     = ch_wdata[32*i +: 32];
            gnt_onehot    = '0;
            gnt_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      id_onehot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         id_onehot[i] = (id_q == ID_W'(i));
      end
   end

   always_comb begin
      state_nxt   = state;
      ch_addr_ok  = '0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      axi.bready  = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_vld) begin
               ch_addr_ok = gnt_onehot;
               state_nxt  = gnt_wr ? WR_AW : RD_A;
            end
         end
         RD_A: begin
            axi.arvalid = 1'b1;
            if (axi.arready) state_nxt = RD_D;
         end
         RD_D: begin
            axi.rready = 1'b1;
            if (axi.rvalid) state_nxt = IDLE;
         end
         WR_AW: begin
            // AW and W are independent; each retires on its own handshake.
            axi.awvalid = !aw_done;
            axi.wvalid  = !w_done;
            if ((aw_done || axi.awready) && (w_done || axi.wready)) state_nxt = WR_B;
         end
         WR_B: begin
            axi.bready = 1'b1;
            if (axi.bvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      done_set = (state == RD_D) && axi.rvalid;
      if (WR_EARLY != 0) done_set = done_set || (axi.wvalid && axi.wready);
      else               done_set = done_set || ((state == WR_B) && axi.bvalid);
      err_set = ((state == RD_D) && axi.rvalid && (axi.rresp != 2'b00)) ||
                ((state == WR_B) && axi.bvalid && (axi.bresp != 2'b00));
   end

   always_comb begin
      case (size_q)
         2'd0:    axi.wstrb = 4'b0001 << addr_q[1:0];
         2'd1:    axi.wstrb = 4'b0011 << {addr_q[1], 1'b0};
         default: axi.wstrb = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state      <= IDLE;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         ch_data_ok <= '0;
         ch_rdata   <= '0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         ch_data_ok <= done_set ? id_onehot : '0;
         bus_err    <= err_set;
         if (state == IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else if (state == WR_AW) begin
            if (axi.awvalid && axi.awready) aw_done <= 1'b1;
            if (axi.wvalid && axi.wready)   w_done  <= 1'b1;
         end
         if ((state == RD_D) && axi.rvalid) ch_rdata <= axi.rdata;
      end
   end

   // NOTE: the request payload is always loaded at grant before anything reads it, so it carries no reset.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && gnt_vld) begin
         id_q    <= gnt_id;
         size_q  <= gnt_size;
         addr_q  <= gnt_addr;
         wdata_q <= gnt_wdata;
      end
   end

   assign axi.arid    = id_q;
   assign axi.araddr  = addr_q;
   assign axi.arsize  = {1'b0, size_q};
   assign axi.arlen   = 4'd0;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;

   assign axi.awid    = id_q;
   assign axi.awaddr  = addr_q;
   assign axi.awsize  = {1'b0, size_q};
   assign axi.awlen   = 4'd0;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'd0;
   assign axi.awprot  = 3'd0;

   assign axi.wid     = id_q;
   assign axi.wdata   = wdata_q;
   assign axi.wlast   = 1'b1;

   // Response IDs and rlast carry no information for single-beat, single-outstanding traffic.
   assign unused_ok = ^{axi.rid, axi.rlast, axi.bid};

endmodule

// File: tb/tb_sram_axi_bridge_mc.sv
// Scoreboard bench: two bridges (WR_EARLY=0 and 1) run in lockstep behind one reactive AXI slave model.
module tb_sram_axi_bridge_mc;
   localparam int NUM_CH = 2;
   localparam int ID_W   = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_a   [NUM_CH];
   logic        wr_a    [NUM_CH];
   logic [1:0]  size_a  [NUM_CH];
   logic [31:0] addr_a  [NUM_CH];
   logic [31:0] wdata_a [NUM_CH];

   logic [NUM_CH-1:0]    ch_req, ch_wr;
   logic [2*NUM_CH-1:0]  ch_size;
   logic [32*NUM_CH-1:0] ch_addr, ch_wdata;

   always_comb begin
      ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_req[i]           = req_a[i];
         ch_wr[i]            = wr_a[i];
         ch_size[2*i +: 2]   = size_a[i];
         ch_addr[32*i +: 32] = addr_a[i];
         ch_wdata[32*i +: 32] = wdata_a[i];
      end
   end

   logic [NUM_CH-1:0] addr_ok0, data_ok0, addr_ok1, data_ok1;
   logic [31:0]       rdata0, rdata1;
   logic              bus_err0, bus_err1;

   sram_axi_bridge_mc_if #(.ID_W(ID_W)) axi0 ();
   sram_axi_bridge_mc_if #(.ID_W(ID_W)) axi1 ();

   sram_axi_bridge_mc #(.NUM_CH(NUM_CH), .WR_EARLY(0), .ID_W(ID_W)) dut0 (
      .clk(clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(addr_ok0), .ch_data_ok(data_ok0),
      .ch_rdata(rdata0), .bus_err(bus_err0), .axi(axi0.master));

   sram_axi_bridge_mc #(.NUM_CH(NUM_CH), .WR_EARLY(1), .ID_W(ID_W)) dut1 (
      .clk(clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(addr_ok1), .ch_data_ok(data_ok1),
      .ch_rdata(rdata1), .bus_err(bus_err1), .axi(axi1.master));

   // The early-completion bridge has identical AXI timing, so it shares the slave's responses.
   assign axi1.arready = axi0.arready;
   assign axi1.rid     = axi0.rid;
   assign axi1.rdata   = axi0.rdata;
   assign axi1.rresp   = axi0.rresp;
   assign axi1.rlast   = axi0.rlast;
   assign axi1.rvalid  = axi0.rvalid;
   assign axi1.awready = axi0.awready;
   assign axi1.wready  = axi0.wready;
   assign axi1.bid     = axi0.bid;
   assign axi1.bresp   = axi0.bresp;
   assign axi1.bvalid  = axi0.bvalid;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   typedef struct {
      int          ch;
      bit          rd;
      logic [31:0] rdata;
      bit          err;
      int          gcyc;
      bit          lat_chk;
   } done_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     addr;
      logic [2:0]      size;
      logic [31:0]     wdata;
      logic [3:0]      wstrb;
   } xfer_t;

   done_t dq0[$], dq1[$];
   xfer_t arq[$], awq[$], wq[$];

   int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
   logic [31:0] slv_rdata = '0;
   logic [1:0]  slv_rresp = '0, slv_bresp = '0;

   int cyc = 0;
   int gnt_cyc [NUM_CH];
   int last_b_cyc = 0, last_dok1_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd0:    return 4'b0001 << a;
         2'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Reactive slave: ready/valid asserted after a programmable number of waiting cycles.
   int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         axi0.arready = 0; axi0.awready = 0; axi0.wready = 0; axi0.rvalid = 0; axi0.bvalid = 0;
         axi0.rid = '0; axi0.rdata = '0; axi0.rresp = '0; axi0.rlast = 0; axi0.bid = '0; axi0.bresp = '0;
         ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
         if (axi0.arvalid) begin axi0.arready = (ar_cnt >= ar_lat); ar_cnt++; end
         else begin axi0.arready = 0; ar_cnt = 0; end
         if (axi0.awvalid) begin axi0.awready = (aw_cnt >= aw_lat); aw_cnt++; end
         else begin axi0.awready = 0; aw_cnt = 0; end
         if (axi0.wvalid) begin axi0.wready = (w_cnt >= w_lat); w_cnt++; end
         else begin axi0.wready = 0; w_cnt = 0; end
         if (axi0.rready) begin axi0.rvalid = (r_cnt >= r_lat); r_cnt++; end
         else begin axi0.rvalid = 0; r_cnt = 0; end
         if (axi0.bready) begin axi0.bvalid = (b_cnt >= b_lat); b_cnt++; end
         else begin axi0.bvalid = 0; b_cnt = 0; end
         axi0.rid = '0; axi0.rdata = slv_rdata; axi0.rresp = slv_rresp; axi0.rlast = 1;
         axi0.bid = '0; axi0.bresp = slv_bresp;
      end
   end

   // Monitor: compares AXI beats and completions against the queued expectations.
   always @(negedge clk) begin
      xfer_t x;
      done_t d;
      #2;
      if (!rst) begin
         if (addr_ok0 != '0) begin
            check("grant_lowest", addr_ok0, ch_req & (~ch_req + 1'b1));
            check("grant_lockstep", addr_ok1, addr_ok0);
         end
         if (axi0.arvalid && axi0.arready) begin
            if (arq.size() == 0) check("ar_unexpected", 1, 0);
            else begin
               x = arq.pop_front();
               check("arid", axi0.arid, x.id);
               check("araddr", axi0.araddr, x.addr);
               check("arsize", axi0.arsize, x.size);
            end
         end
         if (axi0.awvalid && axi0.awready) begin
            if (awq.size() == 0) check("aw_unexpected", 1, 0);
            else begin
               x = awq.pop_front();
               check("awid", axi0.awid, x.id);
               check("awaddr", axi0.awaddr, x.addr);
               check("awsize", axi0.awsize, x.size);
            end
         end
         if (axi0.wvalid && axi0.wready) begin
            if (wq.size() == 0) check("w_unexpected", 1, 0);
            else begin
               x = wq.pop_front();
               check("wid", axi0.wid, x.id);
               check("wdata", axi0.wdata, x.wdata);
               check("wstrb", axi0.wstrb, x.wstrb);
               check("wlast", axi0.wlast, 1);
            end
         end
         if (axi0.bvalid && axi0.bready) last_b_cyc = cyc;

         if (data_ok0 != '0) begin
            if (dq0.size() == 0) check("dok0_spurious", data_ok0, 0);
            else begin
               d = dq0.pop_front();
               check("dok0_ch", data_ok0, 1 << d.ch);
               if (d.rd) check("rdata0", rdata0, d.rdata);
               check("bus_err0", bus_err0, d.err);
               if (d.lat_chk) check("latency0", cyc - d.gcyc, 3);
            end
         end else if (bus_err0) begin
            check("bus_err0_orphan", bus_err0, 0);
         end

         if (data_ok1 != '0) begin
            if (dq1.size() == 0) check("dok1_spurious", data_ok1, 0);
            else begin
               d = dq1.pop_front();
               check("dok1_ch", data_ok1, 1 << d.ch);
               if (d.rd) begin
                  check("rdata1", rdata1, d.rdata);
                  check("bus_err1", bus_err1, d.err);
               end else begin
                  last_dok1_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic issue(input int ch, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err,
                        input bit expect_done, input bit lat_chk);
      int    waited = 0;
      bit    got = 0;
      xfer_t x;
      done_t d;
      @(negedge clk);
      req_a[ch] = 1; wr_a[ch] = wr; size_a[ch] = size; addr_a[ch] = addr; wdata_a[ch] = wdata;
      while (!got && waited < 200) begin
         #1;
         if (addr_ok0[ch]) got = 1;
         else begin waited++; @(negedge clk); end
      end
      check($sformatf("grant_wait_ch%0d", ch), got, 1);
      if (got) begin
         gnt_cyc[ch] = cyc;
         x.id = ID_W'(ch); x.addr = addr; x.size = {1'b0, size}; x.wdata = wdata;
         x.wstrb = exp_strb(size, addr[1:0]);
         if (wr) begin awq.push_back(x); wq.push_back(x); end
         else arq.push_back(x);
         if (expect_done) begin
            d.ch = ch; d.rd = !wr; d.rdata = exp_rdata; d.err = exp_err; d.gcyc = cyc; d.lat_chk = lat_chk;
            dq0.push_back(d); dq1.push_back(d);
         end
      end
      @(negedge clk);
      // Scramble the request after acceptance: the bridge must use its latched copy.
      req_a[ch] = 0; wr_a[ch] = ~wr; size_a[ch] = ~size; addr_a[ch] = ~addr; wdata_a[ch] = ~wdata;
   endtask

   task automatic drain();
      int n = 0;
      while ((dq0.size() + dq1.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      #3;
      check("drain", dq0.size() + dq1.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         req_a[i] = 0; wr_a[i] = 0; size_a[i] = '0; addr_a[i] = '0; wdata_a[i] = '0; gnt_cyc[i] = 0;
      end
      rst = 1;
      repeat (3) @(negedge clk);
      #3;
      check("reset_valids", {axi0.arvalid, axi0.rready, axi0.awvalid, axi0.wvalid, axi0.bready}, 0);
      check("reset_ok", {addr_ok0, data_ok0, bus_err0}, 0);
      check("reset_rdata", rdata0, 0);
      @(negedge clk);
      rst = 0;

      // Zero-wait read on channel 0.
      slv_rdata = 32'hDEAD_BEEF;
      issue(0, 0, 2'd2, 32'h1FC0_0004, 32'h0, 32'hDEAD_BEEF, 0, 1, 1);
      drain();

      // Simultaneous requests: ch0 read wins, ch1 write granted in ch0's completion cycle.
      slv_rdata = 32'h1234_5678;
      fork
         issue(0, 0, 2'd2, 32'h1000_0010, 32'h0, 32'h1234_5678, 0, 1, 1);
         issue(1, 1, 2'd2, 32'h2000_0020, 32'hCAFE_F00D, 32'h0, 0, 1, 1);
      join
      drain();
      check("back_to_back_gap", gnt_cyc[1] - gnt_cyc[0], 3);

      // Strobe generation: byte, half and illegal size 3.
      issue(1, 1, 2'd0, 32'h3000_0003, 32'hAB00_0000, 32'h0, 0, 1, 1);
      issue(0, 1, 2'd1, 32'h3000_0002, 32'h5678_0000, 32'h0, 0, 1, 1);
      issue(0, 1, 2'd3, 32'h3000_0001, 32'h0102_0304, 32'h0, 0, 1, 1);
      drain();

      // AW stalled 5 cycles while W completes at once.
      aw_lat = 5;
      issue(1, 1, 2'd2, 32'h4000_0008, 32'h0BEE_F00D, 32'h0, 0, 1, 0);
      #3;
      check("aw_entry_awvalid", axi0.awvalid, 1);
      check("aw_entry_wvalid", axi0.wvalid, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #3;
         check("aw_stall_awvalid", axi0.awvalid, 1);
         check("aw_stall_wvalid", axi0.wvalid, 0);
         check("aw_stall_bready", axi0.bready, 0);
      end
      @(negedge clk); #3;
      check("aw_done_awvalid", axi0.awvalid, 0);
      check("aw_done_bready", axi0.bready, 1);
      drain();
      aw_lat = 0;

      // Delayed B: early bridge completes on W; next grant waits for B.
      b_lat = 4;
      slv_rdata = 32'h7777_0001;
      issue(0, 1, 2'd2, 32'h5000_0000, 32'hA5A5_5A5A, 32'h0, 0, 1, 0);
      issue(1, 0, 2'd2, 32'h5000_0100, 32'h0, 32'h7777_0001, 0, 1, 0);
      drain();
      check("early_dok_before_b", last_dok1_cyc < last_b_cyc, 1);
      check("grant_after_b", gnt_cyc[1] > last_b_cyc, 1);
      b_lat = 0;

      // Error responses.
      slv_rresp = 2'b10;
      slv_rdata = 32'h0BAD_0BAD;
      issue(0, 0, 2'd2, 32'h6000_0004, 32'h0, 32'h0BAD_0BAD, 1, 1, 1);
      drain();
      slv_rresp = 2'b00;
      slv_bresp = 2'b11;
      issue(1, 1, 2'd2, 32'h6000_0008, 32'h1111_2222, 32'h0, 1, 1, 1);
      drain();
      slv_bresp = 2'b00;

      // Reset while waiting for read data.
      r_lat = 20;
      issue(1, 0, 2'd2, 32'h7000_0000, 32'h0, 32'h0, 0, 0, 0);
      @(negedge clk); #3;
      check("in_rd_d", axi0.rready, 1);
      rst = 1;
      @(negedge clk); #3;
      check("rst_valids0", {axi0.arvalid, axi0.rready, axi0.awvalid, axi0.wvalid, axi0.bready}, 0);
      check("rst_valids1", {axi1.arvalid, axi1.rready, axi1.awvalid, axi1.wvalid, axi1.bready}, 0);
      check("rst_ok0", {addr_ok0, data_ok0, bus_err0}, 0);
      check("rst_ok1", {addr_ok1, data_ok1, bus_err1}, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      @(negedge clk);
      rst = 0;
      r_lat = 0;

      // Recovery after reset.
      slv_rdata = 32'h55AA_55AA;
      issue(0, 0, 2'd2, 32'h7000_0010, 32'h0, 32'h55AA_55AA, 0, 1, 1);
      drain();
      check("queues_empty", arq.size() + awq.size() + wq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
